// File: rtl/xbus_if.sv
// Signal bundle between the two bus masters, the arbiter and the address decoder.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface xbus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Handshake: mX_req is held with its addr/we/wdata until mX_ack, which is a one-cycle pulse
    // carrying rdata/err; a master must not drop or change its request before that pulse.
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_we;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic              m1_we;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;

    logic              bus_sel;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_we;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_trap;
    logic              grant;

    modport slave (
        input  m0_req, m0_addr, m0_we, m0_wdata,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_addr, m1_we, m1_wdata,
        output m1_ack, m1_rdata, m1_err,
        output bus_sel, bus_addr, bus_we, bus_wdata, grant,
        input  bus_rdata, bus_trap
    );

    modport master (
        output m0_req, m0_addr, m0_we, m0_wdata,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_addr, m1_we, m1_wdata,
        input  m1_ack, m1_rdata, m1_err,
        input  bus_sel, bus_addr, bus_we, bus_wdata, grant,
        output bus_rdata, bus_trap
    );
endinterface

// File: rtl/xbus_arbiter.sv
// Two-master arbiter in front of the address decoder: IDLE -> ISSUE (bus driven) -> ACK (pulse to winner).
// Round-robin or fixed-priority selection; decoder read data and trap are registered during ISSUE.
module xbus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter bit PRIO_MODE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    xbus_if.slave      xb,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              grant_q, grant_nxt;
    logic              last_q, last_nxt;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              cand0, cand1;
    logic              win_any, win_id;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    // During ACK the just-served request is still high but already completed, so it is masked.
    always_comb begin
        cand0   = xb.m0_req && !((state == ACK) && !grant_q);
        cand1   = xb.m1_req && !((state == ACK) &&  grant_q);
        win_any = 1'b0;
        win_id  = 1'b0;
        if (PRIO_MODE) begin
            // m1 is only eligible while m0 is not requesting at all, so a busy m0 starves it.
            win_any = cand0 || (cand1 && !xb.m0_req);
            win_id  = !cand0;
        end else begin
            win_any = cand0 || cand1;
            win_id  = (cand0 && cand1) ? !last_q : cand1;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        last_nxt  = last_q;
        case (state)
            IDLE: begin
                if (win_any) begin
                    grant_nxt = win_id;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = ACK;
            ACK: begin
                last_nxt = grant_q;
                if (win_any) begin
                    grant_nxt = win_id;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            last_q  <= last_nxt;
            if (state == ISSUE) begin
                rdata_q <= xb.bus_rdata;
                err_q   <= xb.bus_trap;
            end
        end
    end

    // Bus outputs are forced to zero outside ISSUE so a stale write can never reach a slave.
    always_comb begin
        addr_mux     = grant_q ? xb.m1_addr  : xb.m0_addr;
        wdata_mux    = grant_q ? xb.m1_wdata : xb.m0_wdata;
        xb.bus_sel   = 1'b0;
        xb.bus_addr  = '0;
        xb.bus_we    = 1'b0;
        xb.bus_wdata = '0;
        if (state == ISSUE) begin
            xb.bus_sel   = 1'b1;
            xb.bus_addr  = addr_mux;
            xb.bus_we    = grant_q ? xb.m1_we : xb.m0_we;
            xb.bus_wdata = wdata_mux;
        end
        xb.m0_ack   = (state == ACK) && !grant_q;
        xb.m1_ack   = (state == ACK) &&  grant_q;
        xb.m0_rdata = rdata_q;
        xb.m1_rdata = rdata_q;
        xb.m0_err   = err_q;
        xb.m1_err   = err_q;
        xb.grant    = grant_q;
    end

    assign dbg_state = state;

endmodule
